// File: rtl/mac_feeder_pkg.sv
// Shared sizing, the operand pair type and small helpers for the MAC operand feeder.
package mac_feeder_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned UCNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
    return (&v) ? v : v + UCNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; pushes on full and pops on empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs and launches one per MAC divided-clock slot, holding a/b for two cycles.
module mac_operand_feeder
  import mac_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic              out_valid,
  output logic              phase,
  output logic [LVL_W-1:0]  level,
  output logic [UCNT_W-1:0] underrun_cnt
);

  pair_t             wr_pair, rd_pair;
  pair_t             out_q, out_d;
  logic              valid_q, valid_d;
  logic              phase_q, phase_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic              fifo_full, fifo_empty;
  logic              push, pop, launch;

  assign wr_pair = '{a: in_a, b: in_b};
  // Launch on the CK falling edge so a/b are stable a full cycle around the MAC sample.
  assign launch  = phase_q;
  assign push    = in_valid & ~fifo_full;
  assign pop     = launch & ~fifo_empty;

  sync_fifo #(
    .WIDTH ($bits(pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_pair),
    .rdata (rd_pair),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    phase_d = ~phase_q;
    out_d   = out_q;
    valid_d = valid_q;
    ucnt_d  = ucnt_q;
    if (launch) begin
      if (!fifo_empty) begin
        out_d   = rd_pair;
        valid_d = 1'b1;
      end else begin
        out_d   = '0;
        valid_d = 1'b0;
        ucnt_d  = sat_inc(ucnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign in_ready     = ~fifo_full;
  assign a            = out_q.a;
  assign b            = out_q.b;
  assign out_valid    = valid_q;
  assign phase        = phase_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: reset, single pair, burst/full, underrun saturation.
module tb_mac_operand_feeder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic [3:0] a, b;
  logic       out_valid;
  logic       phase;
  logic [2:0] level;
  logic [7:0] underrun_cnt;

  int   checks;
  int   errors;
  logic ph_exp;
  int   u_exp;

  // Expected state after each edge of the 8-pair burst that starts on a launch edge.
  int bl_lvl  [20] = '{1, 2, 2, 3, 3, 4, 3, 4, 3, 4, 3, 3, 2, 2, 1, 1, 0, 0, 0, 0};
  int bl_a    [20] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 0, 0};
  bit bl_push [20] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  mac_operand_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .phase        (phase),
    .level        (level),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    ph_exp = ~ph_exp;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({phase, a, b, out_valid, level, underrun_cnt, in_ready} !== {1'b0, 8'h00, 1'b0, 3'd0,
        8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got ph=%b a=%0d b=%0d v=%b lvl=%0d u=%0d rdy=%b", phase, a, b,
               out_valid, level, underrun_cnt, in_ready);
    end
    rst = 1'b1; ph_exp = 1'b0; u_exp = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ph_exp == 1'b0) u_exp++;
      checks++;
      if (phase !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL idle_phase[%0d]: got %b want %b", i, phase, (i % 2) == 0);
      end
      checks++;
      if ({a, b, out_valid} !== 9'd0) begin
        errors++;
        $display("FAIL idle_out[%0d]: got a=%0d b=%0d v=%b want 0", i, a, b, out_valid);
      end
    end
    checks++;
    if (underrun_cnt !== 8'd5 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_underrun: got u=%0d rdy=%b want u=5 rdy=1", underrun_cnt, in_ready);
    end
  endtask

  task automatic test_single();
    if (ph_exp) begin
      cyc();
      u_exp++;
    end
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_push: got lvl=%0d v=%b want lvl=1 v=0", level, out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({a, b, out_valid, level} !== {4'd3, 4'd5, 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL single_hold[%0d]: got a=%0d b=%0d v=%b lvl=%0d want 3 5 1 0", i, a, b,
                 out_valid, level);
      end
    end
    cyc();
    u_exp++;
    checks++;
    if ({a, b, out_valid} !== 9'd0 || underrun_cnt !== 8'(u_exp)) begin
      errors++;
      $display("FAIL single_drain: got a=%0d v=%b u=%0d want 0 0 %0d", a, out_valid,
               underrun_cnt, u_exp);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int ea, eb;
    if (!ph_exp) cyc();
    idx = 0;
    for (int e = 0; e < 20; e++) begin
      if (idx < 8) begin
        in_valid = 1'b1; in_a = 4'(idx + 1); in_b = 4'(14 - idx);
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (bl_push[e]) idx++;
      ea = bl_a[e];
      eb = (ea != 0) ? 15 - ea : 0;
      checks++;
      if (level !== 3'(bl_lvl[e]) || in_ready !== (bl_lvl[e] != 4)) begin
        errors++;
        $display("FAIL burst_level[%0d]: got lvl=%0d rdy=%b want lvl=%0d rdy=%b", e, level,
                 in_ready, bl_lvl[e], bl_lvl[e] != 4);
      end
      checks++;
      if (a !== 4'(ea) || b !== 4'(eb) || out_valid !== (ea != 0)) begin
        errors++;
        $display("FAIL burst_out[%0d]: got a=%0d b=%0d v=%b want a=%0d b=%0d v=%b", e, a, b,
                 out_valid, ea, eb, ea != 0);
      end
    end
    u_exp += 2;
    checks++;
    if (underrun_cnt !== 8'(u_exp)) begin
      errors++;
      $display("FAIL burst_underrun: got %0d want %0d", underrun_cnt, u_exp);
    end
  endtask

  task automatic test_underrun_saturate();
    if (!ph_exp) cyc();
    in_valid = 1'b1; in_a = 4'd10; in_b = 4'd4;
    cyc();
    u_exp++;
    checks++;
    if (underrun_cnt !== 8'(u_exp) || level !== 3'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_launch_push: got u=%0d lvl=%0d v=%b want u=%0d lvl=1 v=0",
               underrun_cnt, level, out_valid, u_exp);
    end
    in_a = 4'd6; in_b = 4'd9;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({a, b, out_valid} !== ((i < 2) ? {4'd10, 4'd4, 1'b1} : {4'd6, 4'd9, 1'b1})) begin
        errors++;
        $display("FAIL stop_slot[%0d]: got a=%0d b=%0d v=%b", i, a, b, out_valid);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (ph_exp == 1'b0) u_exp++;
      checks++;
      if ({a, b, out_valid} !== 9'd0 || underrun_cnt !== 8'(u_exp)) begin
        errors++;
        $display("FAIL stop_empty[%0d]: got a=%0d v=%b u=%0d want 0 0 %0d", i, a, out_valid,
                 underrun_cnt, u_exp);
      end
    end
    repeat (600) cyc();
    checks++;
    if (underrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL underrun_sat: got %0d want 255", underrun_cnt);
    end
    repeat (4) cyc();
    checks++;
    if (underrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL underrun_hold: got %0d want 255", underrun_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    if (!ph_exp) cyc();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 4'(i + 2); in_b = 4'(i + 7);
      cyc();
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd3 || a !== 4'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_prefill: got lvl=%0d a=%0d v=%b want 3 2 1", level, a, out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({phase, a, b, out_valid, level, underrun_cnt, in_ready} !== {1'b0, 8'h00, 1'b0, 3'd0,
        8'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: got ph=%b a=%0d b=%0d v=%b lvl=%0d u=%0d rdy=%b", phase, a, b,
               out_valid, level, underrun_cnt, in_ready);
    end
    @(negedge clk);
    rst = 1'b1; ph_exp = 1'b0; u_exp = 0;
    in_valid = 1'b1; in_a = 4'd12; in_b = 4'd1;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_push: got lvl=%0d v=%b want 1 0", level, out_valid);
    end
    cyc();
    checks++;
    if ({a, b, out_valid, level, underrun_cnt} !== {4'd12, 4'd1, 1'b1, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL post_reset_pop: got a=%0d b=%0d v=%b lvl=%0d u=%0d want 12 1 1 0 0", a, b,
               out_valid, level, underrun_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ph_exp = 1'b0;
    u_exp  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun_saturate();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
